// File: rtl/pc_1_to_n_feed_ctrl.sv
// Feed controller in front of a 1-to-N converter: collects N_LANES tagged
// blocks per frame from a valid/ready source and, on flush, pads a partial
// frame out to completion with an idle block.
module pc_1_to_n_feed_ctrl #(
    parameter int                        NB_DATA_TAGGED = 67,
    parameter int                        N_LANES        = 20,
    parameter logic [NB_DATA_TAGGED-1:0] PAD_BLOCK      = {1'b0, 2'b10, 8'h1E, 56'h0},
    localparam int                       NB_INDEX       = $clog2(N_LANES)
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_src_valid,
    input  logic [NB_DATA_TAGGED-1:0] i_src_data,
    output logic                      o_src_ready,
    input  logic                      i_dst_ready,
    input  logic                      i_flush,
    output logic                      o_conv_valid,
    output logic [NB_DATA_TAGGED-1:0] o_conv_data,
    output logic [NB_INDEX-1:0]       o_lane_index,
    output logic                      o_frame_start,
    output logic                      o_frame_done,
    output logic [NB_INDEX:0]         o_pad_count,
    output logic                      o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD
    } state_t;

    localparam logic [NB_INDEX-1:0] LAST_SLOT = NB_INDEX'(N_LANES - 1);

    state_t                    state_q;
    logic [NB_INDEX-1:0]       slot_q;        // slot of the next block to emit
    logic [NB_INDEX:0]         pads_q;        // pads emitted so far in this frame
    logic                      conv_valid_q;
    logic [NB_DATA_TAGGED-1:0] conv_data_q;
    logic [NB_INDEX-1:0]       lane_index_q;
    logic                      frame_start_q;
    logic                      frame_done_q;
    logic [NB_INDEX:0]         pad_count_q;

    logic src_ready_d;
    logic xfer_d;
    logic last_slot_d;

    // Source handshake: downstream readiness only gates the start of a frame.
    always_comb begin
        src_ready_d = 1'b0;
        if (i_enable) begin
            src_ready_d = ((state_q == IDLE) && i_dst_ready) || (state_q == FILL);
        end
        xfer_d      = i_src_valid && src_ready_d;
        last_slot_d = (slot_q == LAST_SLOT);
    end

    // Frame FSM with registered outputs; pulses clear every cycle, even when disabled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            pads_q        <= '0;
            conv_valid_q  <= 1'b0;
            conv_data_q   <= '0;
            lane_index_q  <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            pad_count_q   <= '0;
        end else begin
            conv_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (i_enable) begin
                case (state_q)
                    IDLE: begin
                        if (xfer_d) begin
                            conv_valid_q  <= 1'b1;
                            conv_data_q   <= i_src_data;
                            lane_index_q  <= '0;
                            frame_start_q <= 1'b1;
                            slot_q        <= NB_INDEX'(1);
                            pads_q        <= '0;
                            state_q       <= FILL;
                        end
                    end
                    FILL: begin
                        // A transfer coinciding with flush is taken first; if it
                        // completes the frame the flush has nothing left to pad.
                        if (xfer_d) begin
                            conv_valid_q <= 1'b1;
                            conv_data_q  <= i_src_data;
                            lane_index_q <= slot_q;
                            if (last_slot_d) begin
                                frame_done_q <= 1'b1;
                                pad_count_q  <= pads_q;
                                slot_q       <= '0;
                                state_q      <= IDLE;
                            end else begin
                                slot_q <= slot_q + 1'b1;
                                if (i_flush) begin
                                    state_q <= PAD;
                                end
                            end
                        end else if (i_flush) begin
                            state_q <= PAD;
                        end
                    end
                    PAD: begin
                        conv_valid_q <= 1'b1;
                        conv_data_q  <= PAD_BLOCK;
                        lane_index_q <= slot_q;
                        if (last_slot_d) begin
                            frame_done_q <= 1'b1;
                            pad_count_q  <= pads_q + 1'b1;
                            slot_q       <= '0;
                            state_q      <= IDLE;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                            pads_q <= pads_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        slot_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_src_ready   = src_ready_d;
    assign o_conv_valid  = conv_valid_q;
    assign o_conv_data   = conv_data_q;
    assign o_lane_index  = lane_index_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done_q;
    assign o_pad_count   = pad_count_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pc_1_to_n_feed_ctrl.sv
// Directed table-driven bench for pc_1_to_n_feed_ctrl with N_LANES=4.
module tb_pc_1_to_n_feed_ctrl;

    localparam int          NB = 67;
    localparam logic [66:0] PADB = {1'b0, 2'b10, 8'h1E, 56'h0};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        src_valid;
    logic [66:0] src_data;
    logic        src_ready;
    logic        dst_ready;
    logic        flush;
    logic        conv_valid;
    logic [66:0] conv_data;
    logic [1:0]  lane_index;
    logic        frame_start;
    logic        frame_done;
    logic [2:0]  pad_count;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    pc_1_to_n_feed_ctrl #(
        .NB_DATA_TAGGED(NB),
        .N_LANES(4)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_enable     (en),
        .i_src_valid  (src_valid),
        .i_src_data   (src_data),
        .o_src_ready  (src_ready),
        .i_dst_ready  (dst_ready),
        .i_flush      (flush),
        .o_conv_valid (conv_valid),
        .o_conv_data  (conv_data),
        .o_lane_index (lane_index),
        .o_frame_start(frame_start),
        .o_frame_done (frame_done),
        .o_pad_count  (pad_count),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic        v;
        logic [66:0] d;
        logic        dr;
        logic        fl;
        logic        rdy;
        logic        cv;
        logic [66:0] cd;
        logic [1:0]  idx;
        logic        fs;
        logic        fd;
        logic [2:0]  pc;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic v, input logic [66:0] d,
                                input logic dr, input logic fl, input logic rdy,
                                input logic cv, input logic [66:0] cd, input logic [1:0] idx,
                                input logic fs, input logic fd, input logic [2:0] pc,
                                input logic b);
        vec_t r;
        r.en = e; r.v = v; r.d = d; r.dr = dr; r.fl = fl;
        r.rdy = rdy; r.cv = cv; r.cd = cd; r.idx = idx;
        r.fs = fs; r.fd = fd; r.pc = pc; r.busy = b;
        return r;
    endfunction

    task automatic add(input vec_t r);
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one cycle at the falling edge, check ready before the rising
    // edge and the registered outputs just after it.
    task automatic apply(input vec_t r, input string tag);
        @(negedge clk);
        en = r.en; src_valid = r.v; src_data = r.d; dst_ready = r.dr; flush = r.fl;
        #1;
        chk({tag, ".rdy"}, 67'(src_ready), 67'(r.rdy));
        @(posedge clk);
        #1;
        chk({tag, ".cv"}, 67'(conv_valid), 67'(r.cv));
        if (r.cv) begin
            chk({tag, ".cd"}, conv_data, r.cd);
            chk({tag, ".idx"}, 67'(lane_index), 67'(r.idx));
        end
        chk({tag, ".fs"}, 67'(frame_start), 67'(r.fs));
        chk({tag, ".fd"}, 67'(frame_done), 67'(r.fd));
        chk({tag, ".pc"}, 67'(pad_count), 67'(r.pc));
        chk({tag, ".busy"}, 67'(busy), 67'(r.busy));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cv"}, 67'(conv_valid), '0);
        chk({tag, ".cd"}, conv_data, '0);
        chk({tag, ".idx"}, 67'(lane_index), '0);
        chk({tag, ".fs"}, 67'(frame_start), '0);
        chk({tag, ".fd"}, 67'(frame_done), '0);
        chk({tag, ".pc"}, 67'(pad_count), '0);
        chk({tag, ".busy"}, 67'(busy), '0);
    endtask

    initial begin
        //          en v  d      dr fl  rdy cv cd     idx fs fd pc busy
        // Back-to-back frames 0x1..0x8
        for (int i = 0; i < 8; i++) begin
            add(mk(1, 1, 67'(i + 1), 1, 0, 1, 1, 67'(i + 1), 2'(i % 4),
                   (i % 4) == 0, (i % 4) == 3, 0, (i % 4) != 3));
        end
        // Downstream not ready: no start for 5 cycles, then frame with
        // dst_ready dropped mid-frame
        for (int i = 0; i < 5; i++) add(mk(1, 1, 67'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk(1, 1, 67'h9,  1, 0, 1, 1, 67'h9,  0, 1, 0, 0, 1));
        add(mk(1, 1, 67'h10, 0, 0, 1, 1, 67'h10, 1, 0, 0, 0, 1));
        add(mk(1, 1, 67'h11, 0, 0, 1, 1, 67'h11, 2, 0, 0, 0, 1));
        add(mk(1, 1, 67'h12, 0, 0, 1, 1, 67'h12, 3, 0, 1, 0, 0));
        // Flush after two blocks: pads at slots 2,3; source blocked in PAD
        add(mk(1, 1, 67'hA,  1, 0, 1, 1, 67'hA,  0, 1, 0, 0, 1));
        add(mk(1, 1, 67'hB,  1, 0, 1, 1, 67'hB,  1, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 1, 1, 0, 67'h0,  0, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  0, 0, 0, 1, PADB,   2, 0, 0, 0, 1));
        add(mk(1, 1, 67'h77, 1, 0, 0, 1, PADB,   3, 0, 1, 2, 0));
        add(mk(1, 0, 67'h0,  1, 0, 1, 0, 67'h0,  0, 0, 0, 2, 0));
        // Flush with the last-slot transfer is ignored; flush in IDLE is ignored
        add(mk(1, 1, 67'h21, 1, 0, 1, 1, 67'h21, 0, 1, 0, 2, 1));
        add(mk(1, 1, 67'h22, 1, 0, 1, 1, 67'h22, 1, 0, 0, 2, 1));
        add(mk(1, 1, 67'h23, 1, 0, 1, 1, 67'h23, 2, 0, 0, 2, 1));
        add(mk(1, 1, 67'h24, 1, 1, 1, 1, 67'h24, 3, 0, 1, 0, 0));
        add(mk(1, 0, 67'h0,  1, 1, 1, 0, 67'h0,  0, 0, 0, 0, 0));
        add(mk(1, 0, 67'h0,  1, 0, 1, 0, 67'h0,  0, 0, 0, 0, 0));
        // Flush with a mid-frame transfer: block accepted, then pads; flush in PAD ignored
        add(mk(1, 1, 67'h31, 1, 0, 1, 1, 67'h31, 0, 1, 0, 0, 1));
        add(mk(1, 1, 67'h32, 1, 1, 1, 1, 67'h32, 1, 0, 0, 0, 1));
        add(mk(1, 1, 67'h33, 1, 1, 0, 1, PADB,   2, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 0, 0, 1, PADB,   3, 0, 1, 2, 0));
        // Enable low for 3 cycles mid-frame, then a source gap, then resume at slot 2
        add(mk(1, 1, 67'h41, 1, 0, 1, 1, 67'h41, 0, 1, 0, 2, 1));
        add(mk(1, 1, 67'h42, 1, 0, 1, 1, 67'h42, 1, 0, 0, 2, 1));
        for (int i = 0; i < 3; i++) add(mk(0, 1, 67'h99, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1));
        add(mk(1, 0, 67'h0,  0, 0, 1, 0, 67'h0,  0, 0, 0, 2, 1));
        add(mk(1, 1, 67'h43, 1, 0, 1, 1, 67'h43, 2, 0, 0, 2, 1));
        add(mk(1, 1, 67'h44, 1, 0, 1, 1, 67'h44, 3, 0, 1, 0, 0));
        // Flush right after slot 0: three pads
        add(mk(1, 1, 67'h51, 1, 0, 1, 1, 67'h51, 0, 1, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 1, 1, 0, 67'h0,  0, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 0, 0, 1, PADB,   1, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 0, 0, 1, PADB,   2, 0, 0, 0, 1));
        add(mk(1, 0, 67'h0,  1, 0, 0, 1, PADB,   3, 0, 1, 3, 0));

        en = 1'b1; src_valid = 1'b0; src_data = '0; dst_ready = 1'b1; flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset in the middle of a frame after slot 2
        apply(mk(1, 1, 67'h61, 1, 0, 1, 1, 67'h61, 0, 1, 0, 3, 1), "r0");
        apply(mk(1, 1, 67'h62, 1, 0, 1, 1, 67'h62, 1, 0, 0, 3, 1), "r1");
        apply(mk(1, 1, 67'h63, 1, 0, 1, 1, 67'h63, 2, 0, 0, 3, 1), "r2");
        @(negedge clk);
        src_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 1, 67'h71, 1, 0, 1, 1, 67'h71, 0, 1, 0, 0, 1), "r3");
        apply(mk(1, 1, 67'h72, 1, 0, 1, 1, 67'h72, 1, 0, 0, 0, 1), "r4");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
